// File: rtl/complex_nr_mult_seq.sv
// Sequential complex multiplier: (a+jb)(c+jd) over four cycles
// on one shared signed multiplier, result on a valid/ready port.
module complex_nr_mult_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_rst,
  input  logic                    op_val,
  output logic                    op_rdy,
  input  logic [DATA_WIDTH-1:0]   op_1_re,
  input  logic [DATA_WIDTH-1:0]   op_1_im,
  input  logic [DATA_WIDTH-1:0]   op_2_re,
  input  logic [DATA_WIDTH-1:0]   op_2_im,
  output logic                    res_val,
  input  logic                    res_ready,
  output logic [2*DATA_WIDTH:0]   res_re,
  output logic [2*DATA_WIDTH:0]   res_im
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = PW + 1;

  typedef enum logic [2:0] {
    IDLE,
    MUL_AC,
    MUL_BD,
    MUL_AD,
    MUL_BC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic signed [DATA_WIDTH-1:0] ma, mb;
  logic signed [PW-1:0]         prod;
  logic signed [RW-1:0]         prod_x;
  logic signed [RW-1:0]         acc_re_q, acc_im_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (sw_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (op_val) state_d = MUL_AC;
      MUL_AC:  state_d = MUL_BD;
      MUL_BD:  state_d = MUL_AD;
      MUL_AD:  state_d = MUL_BC;
      MUL_BC:  state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // multiplier operands steered by the current product term
  always_comb begin
    ma = a_q;
    mb = c_q;
    unique case (state_q)
      MUL_BD: begin ma = b_q; mb = d_q; end
      MUL_AD: begin ma = a_q; mb = d_q; end
      MUL_BC: begin ma = b_q; mb = c_q; end
      default: ;
    endcase
  end

  assign prod   = ma * mb;
  assign prod_x = {prod[PW-1], prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else if (sw_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (op_val) begin
            a_q      <= op_1_re;
            b_q      <= op_1_im;
            c_q      <= op_2_re;
            d_q      <= op_2_im;
            acc_re_q <= '0;
            acc_im_q <= '0;
          end
        end
        MUL_AC:  acc_re_q <= prod_x;
        MUL_BD:  acc_re_q <= acc_re_q - prod_x;
        MUL_AD:  acc_im_q <= prod_x;
        MUL_BC:  acc_im_q <= acc_im_q + prod_x;
        default: ;
      endcase
    end
  end

  assign op_rdy  = (state_q == IDLE);
  assign res_val = (state_q == DONE);
  assign res_re  = acc_re_q;
  assign res_im  = acc_im_q;

endmodule

// File: tb/tb_complex_nr_mult_seq.sv
// Bench for complex_nr_mult_seq: directed plan cases plus random
// traffic, checked by a queue-based scoreboard and protocol model.
module tb_complex_nr_mult_seq;

  localparam int DW = 8;
  localparam int RW = 2 * DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sw_rst = 1'b0;
  logic          op_val = 1'b0;
  logic          op_rdy;
  logic [DW-1:0] op_1_re = '0;
  logic [DW-1:0] op_1_im = '0;
  logic [DW-1:0] op_2_re = '0;
  logic [DW-1:0] op_2_im = '0;
  logic          res_val;
  logic          res_ready = 1'b1;
  logic [RW-1:0] res_re;
  logic [RW-1:0] res_im;

  complex_nr_mult_seq #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst    (sw_rst),
    .op_val    (op_val),
    .op_rdy    (op_rdy),
    .op_1_re   (op_1_re),
    .op_1_im   (op_1_im),
    .op_2_re   (op_2_re),
    .op_2_im   (op_2_im),
    .res_val   (res_val),
    .res_ready (res_ready),
    .res_re    (res_re),
    .res_im    (res_im)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int n_res   = 0;

  typedef struct {
    logic [RW-1:0] re;
    logic [RW-1:0] im;
  } exp_t;

  exp_t sb[$];
  bit   busy = 1'b0;
  int   acc_cyc = 0;

  task automatic chk(string nm, logic [RW-1:0] act,
                     logic [RW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, $signed(act), act, $signed(exp), exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // protocol model + scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    bit   ev;
    int   pr;
    int   pi;
    exp_t e;
    if (rst) begin
      busy = 1'b0;
      sb.delete();
    end
    ev = busy && (cyc >= acc_cyc + 5);
    chk("op_rdy", {16'd0, op_rdy}, {16'd0, !busy});
    chk("res_val", {16'd0, res_val}, {16'd0, ev});
    if (res_val && ev) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 17'd0, 17'd1);
      end else begin
        chk("sb_re", res_re, sb[0].re);
        chk("sb_im", res_im, sb[0].im);
      end
    end
    if (!rst) begin
      if (sw_rst) begin
        busy = 1'b0;
        sb.delete();
      end else if (!busy && op_val) begin
        pr = $signed(op_1_re) * $signed(op_2_re)
           - $signed(op_1_im) * $signed(op_2_im);
        pi = $signed(op_1_re) * $signed(op_2_im)
           + $signed(op_1_im) * $signed(op_2_re);
        e.re = pr[RW-1:0];
        e.im = pi[RW-1:0];
        sb.push_back(e);
        busy = 1'b1;
        acc_cyc = cyc;
      end else if (ev && res_ready) begin
        void'(sb.pop_front());
        busy = 1'b0;
        n_res++;
      end
    end
  end

  task automatic set_ops(int a, int b, int c, int d);
    op_1_re = a[DW-1:0];
    op_1_im = b[DW-1:0];
    op_2_re = c[DW-1:0];
    op_2_im = d[DW-1:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(int a, int b, int c, int d);
    set_ops(a, b, c, d);
    op_val = 1'b1;
    step();
    op_val = 1'b0;
  endtask

  task automatic wait_res(string nm, int er, int ei);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_val) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk({nm, "_timeout"}, 17'd0, 17'd1);
    end else begin
      chk({nm, "_re"}, res_re, er[RW-1:0]);
      chk({nm, "_im"}, res_im, ei[RW-1:0]);
    end
    step();
  endtask

  initial begin
    logic [RW-1:0] hold_re;
    logic [RW-1:0] hold_im;

    step();
    step();
    chk("rst_op_rdy", {16'd0, op_rdy}, 17'd1);
    chk("rst_res_val", {16'd0, res_val}, 17'd0);
    chk("rst_res_re", res_re, 17'd0);
    chk("rst_res_im", res_im, 17'd0);
    rst = 1'b0;
    step();

    // defaults
    pulse(2, 4, 3, 6);
    wait_res("dflt", -18, 24);

    // extremes
    pulse(-128, -128, -128, 127);
    wait_res("ext1", 32640, 128);
    pulse(-128, -128, -128, -128);
    wait_res("ext2", 0, 32768);

    // backpressure with new operands offered
    res_ready = 1'b0;
    pulse(5, -3, 7, 2);
    set_ops(1, 2, 3, 4);
    op_val = 1'b1;
    wait_res("bp", 41, -11);
    hold_re = res_re;
    hold_im = res_im;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_val", {16'd0, res_val}, 17'd1);
      chk("bp_rdy", {16'd0, op_rdy}, 17'd0);
      chk("bp_re_hold", res_re, hold_re);
      chk("bp_im_hold", res_im, hold_im);
    end
    step();
    res_ready = 1'b1;
    step();
    chk("bp_idle", {16'd0, op_rdy}, 17'd1);
    step();
    op_val = 1'b0;
    wait_res("bp_next", -5, 10);

    // back-to-back with op_val held
    set_ops(1, 1, 1, 1);
    op_val = 1'b1;
    step();
    set_ops(0, 1, 0, 1);
    wait_res("b2b1", 0, 2);
    step();
    op_val = 1'b0;
    wait_res("b2b2", -1, 0);

    // software reset in MUL_AD
    pulse(9, -7, 11, 13);
    step();
    step();
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("swr_rdy", {16'd0, op_rdy}, 17'd1);
    chk("swr_val", {16'd0, res_val}, 17'd0);
    chk("swr_re", res_re, 17'd0);
    chk("swr_im", res_im, 17'd0);
    pulse(-6, 5, 4, -3);
    wait_res("swr_next", -9, 38);

    // async reset while holding DONE
    res_ready = 1'b0;
    pulse(3, 3, 3, 3);
    wait_res("arst_pre", 0, 18);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_val", {16'd0, res_val}, 17'd0);
    chk("arst_rdy", {16'd0, op_rdy}, 17'd1);
    chk("arst_re", res_re, 17'd0);
    chk("arst_im", res_im, 17'd0);
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      op_val    = ($urandom_range(0, 2) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      sw_rst    = ($urandom_range(0, 79) == 0);
      op_1_re   = DW'($urandom);
      op_1_im   = DW'($urandom);
      op_2_re   = DW'($urandom);
      op_2_im   = DW'($urandom);
      step();
    end
    op_val    = 1'b0;
    sw_rst    = 1'b0;
    res_ready = 1'b1;
    repeat (10) step();
    chk("results_seen", {16'd0, n_res > 50}, 17'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
